dpram_port_arbiter: RTL and testbench

Shares the 4096 x 64 dual-port RAM between NW write requesters and NR read requesters. Each RAM port has its own round-robin arbiter. RAM-side outputs are registered. Read data is returned to the winning requester, tagged by a one-hot valid, after a fixed latency. The block sits between the client agents and the RAM, and drives the RAM's wr/wr_add/in and rd/rd_add pins directly.

---
 rtl/dpram_port_arbiter.sv | 91 +++++++++
 tb/tb_dpram_port_arbiter.sv | 162 ++++++++++++++++
 2 files changed

// File: rtl/dpram_port_arbiter.sv
// dpram_port_arbiter: round-robin write/read port arbitration for a dual-port RAM with registered RAM-side outputs
module dpram_port_arbiter #(
  parameter int NW = 2,
  parameter int NR = 2,
  parameter int AW = 12,
  parameter int DW = 64,
  parameter int RD_LAT = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [NW-1:0]    wreq,
  input  logic [NW*AW-1:0] waddr,
  input  logic [NW*DW-1:0] wdata,
  output logic [NW-1:0]    wgnt,
  input  logic [NR-1:0]    rreq,
  input  logic [NR*AW-1:0] raddr,
  output logic [NR-1:0]    rgnt,
  output logic [NR-1:0]    rvalid,
  output logic [DW-1:0]    rdata,
  output logic             wr,
  output logic [AW-1:0]    wr_add,
  output logic [DW-1:0]    in,
  output logic             rd,
  output logic [AW-1:0]    rd_add,
  input  logic [DW-1:0]    out
);
  logic [NW-1:0] wlast;
  logic [NR-1:0] rlast, rsel;
  logic [AW-1:0] wa, ra;
  logic [DW-1:0] wd;
  logic [NR-1:0] pipe [0:RD_LAT];
  logic hazard;
  // Pointers are one-hot last winners, so every rotated index is a constant after unrolling
  always_comb begin
    wgnt = '0;
    for (int k = 1; k <= NW; k++)
      for (int i = 0; i < NW; i++)
        if (wlast[i] && wreq[(i + k) % NW] && wgnt == '0) wgnt[(i + k) % NW] = 1'b1;
  end
  always_comb begin
    rsel = '0;
    for (int k = 1; k <= NR; k++)
      for (int i = 0; i < NR; i++)
        if (rlast[i] && rreq[(i + k) % NR] && rsel == '0) rsel[(i + k) % NR] = 1'b1;
  end
  always_comb begin
    wa = '0;
    wd = '0;
    for (int i = 0; i < NW; i++)
      if (wgnt[i]) begin
        wa = waddr[i*AW +: AW];
        wd = wdata[i*DW +: DW];
      end
  end
  always_comb begin
    ra = '0;
    for (int i = 0; i < NR; i++)
      if (rsel[i]) ra = raddr[i*AW +: AW];
  end
  // Write-first: a read colliding with this cycle's write waits one cycle to see the new data
  assign hazard = (|wgnt) && (|rsel) && (ra == wa);
  assign rgnt = hazard ? '0 : rsel;
  assign rvalid = pipe[RD_LAT];
  assign rdata = out;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr <= 1'b0;
      rd <= 1'b0;
      wr_add <= '0;
      rd_add <= '0;
      in <= '0;
      wlast <= NW'(1) << (NW - 1);
      rlast <= NR'(1) << (NR - 1);
      for (int i = 0; i <= RD_LAT; i++) pipe[i] <= '0;
    end else begin
      wr <= |wgnt;
      rd <= |rgnt;
      if (|wgnt) begin
        wr_add <= wa;
        in <= wd;
        wlast <= wgnt;
      end
      if (|rgnt) begin
        rd_add <= ra;
        rlast <= rgnt;
      end
      pipe[0] <= rgnt;
      for (int i = 1; i <= RD_LAT; i++) pipe[i] <= pipe[i-1];
    end
  end
endmodule

// File: tb/tb_dpram_port_arbiter.sv
// tb_dpram_port_arbiter: table-driven check of arbitration, RAM pins, hazard stall and mid-run reset
module tb_dpram_port_arbiter;
  localparam int AW = 12;
  localparam int DW = 64;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [1:0] wreq = '0, rreq = '0, wgnt, rgnt, rvalid;
  logic [2*AW-1:0] waddr = '0, raddr = '0;
  logic [2*DW-1:0] wdata = '0;
  logic [DW-1:0] rdata, in, out;
  logic wr, rd;
  logic [AW-1:0] wr_add, rd_add;
  logic [DW-1:0] mem [0:4095];
  int checks = 0;
  int fails = 0;

  dpram_port_arbiter #(.NW(2), .NR(2), .AW(AW), .DW(DW), .RD_LAT(1)) dut (
    .clk(clk), .rst_n(rst_n), .wreq(wreq), .waddr(waddr), .wdata(wdata), .wgnt(wgnt),
    .rreq(rreq), .raddr(raddr), .rgnt(rgnt), .rvalid(rvalid), .rdata(rdata),
    .wr(wr), .wr_add(wr_add), .in(in), .rd(rd), .rd_add(rd_add), .out(out)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (wr) mem[wr_add] <= in;
    if (rd) out <= mem[rd_add];
  end

  typedef struct {
    logic [1:0] wreq;
    logic [AW-1:0] wa0, wa1;
    logic [DW-1:0] wd0, wd1;
    logic [1:0] rreq;
    logic [AW-1:0] ra0, ra1;
    logic [1:0] wgnt, rgnt;
    logic wr;
    logic [AW-1:0] wa;
    logic [DW-1:0] din;
    logic rd;
    logic [AW-1:0] ra;
    logic [1:0] rv;
    logic [DW-1:0] rdat;
  } vec_t;

  vec_t v [23];

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic [1:0] wq, input logic [AW-1:0] wa0, input logic [AW-1:0] wa1,
                       input logic [DW-1:0] wd0, input logic [DW-1:0] wd1,
                       input logic [1:0] rq, input logic [AW-1:0] ra0, input logic [AW-1:0] ra1);
    wreq = wq;
    waddr = {wa1, wa0};
    wdata = {wd1, wd0};
    rreq = rq;
    raddr = {ra1, ra0};
  endtask

  localparam logic [DW-1:0] A = 64'hA5A5;
  localparam logic [DW-1:0] B = 64'h5A5A;
  localparam logic [DW-1:0] D = 64'hDEADBEEF;
  localparam logic [DW-1:0] Z = 64'h0;

  initial begin
    v[0]  = '{2'b11, 12'h010, 12'h020, A, B, 2'b00, 12'h000, 12'h000, 2'b01, 2'b00, 1'b0, 12'h000, Z, 1'b0, 12'h000, 2'b00, Z};
    v[1]  = '{2'b11, 12'h010, 12'h020, A, B, 2'b00, 12'h000, 12'h000, 2'b10, 2'b00, 1'b1, 12'h010, A, 1'b0, 12'h000, 2'b00, Z};
    v[2]  = '{2'b11, 12'h010, 12'h020, A, B, 2'b00, 12'h000, 12'h000, 2'b01, 2'b00, 1'b1, 12'h020, B, 1'b0, 12'h000, 2'b00, Z};
    v[3]  = '{2'b11, 12'h010, 12'h020, A, B, 2'b00, 12'h000, 12'h000, 2'b10, 2'b00, 1'b1, 12'h010, A, 1'b0, 12'h000, 2'b00, Z};
    v[4]  = '{2'b01, 12'hFFF, 12'h000, D, Z, 2'b00, 12'h000, 12'h000, 2'b01, 2'b00, 1'b1, 12'h020, B, 1'b0, 12'h000, 2'b00, Z};
    v[5]  = '{2'b00, 12'h000, 12'h000, Z, Z, 2'b10, 12'h000, 12'hFFF, 2'b00, 2'b10, 1'b1, 12'hFFF, D, 1'b0, 12'h000, 2'b00, Z};
    v[6]  = '{2'b00, 12'h000, 12'h000, Z, Z, 2'b00, 12'h000, 12'h000, 2'b00, 2'b00, 1'b0, 12'hFFF, D, 1'b1, 12'hFFF, 2'b00, Z};
    v[7]  = '{2'b00, 12'h000, 12'h000, Z, Z, 2'b00, 12'h000, 12'h000, 2'b00, 2'b00, 1'b0, 12'hFFF, D, 1'b0, 12'hFFF, 2'b10, D};
    v[8]  = '{2'b01, 12'h123, 12'h000, 64'h77, Z, 2'b01, 12'h123, 12'h000, 2'b01, 2'b00, 1'b0, 12'hFFF, D, 1'b0, 12'hFFF, 2'b00, Z};
    v[9]  = '{2'b00, 12'h000, 12'h000, Z, Z, 2'b01, 12'h123, 12'h000, 2'b00, 2'b01, 1'b1, 12'h123, 64'h77, 1'b0, 12'hFFF, 2'b00, Z};
    v[10] = '{2'b00, 12'h000, 12'h000, Z, Z, 2'b00, 12'h000, 12'h000, 2'b00, 2'b00, 1'b0, 12'h123, 64'h77, 1'b1, 12'h123, 2'b00, Z};
    v[11] = '{2'b00, 12'h000, 12'h000, Z, Z, 2'b00, 12'h000, 12'h000, 2'b00, 2'b00, 1'b0, 12'h123, 64'h77, 1'b0, 12'h123, 2'b01, 64'h77};
    v[12] = '{2'b00, 12'h000, 12'h000, Z, Z, 2'b11, 12'h010, 12'h020, 2'b00, 2'b10, 1'b0, 12'h123, 64'h77, 1'b0, 12'h123, 2'b00, Z};
    v[13] = '{2'b00, 12'h000, 12'h000, Z, Z, 2'b11, 12'h010, 12'h020, 2'b00, 2'b01, 1'b0, 12'h123, 64'h77, 1'b1, 12'h020, 2'b00, Z};
    v[14] = '{2'b00, 12'h000, 12'h000, Z, Z, 2'b11, 12'h010, 12'h020, 2'b00, 2'b10, 1'b0, 12'h123, 64'h77, 1'b1, 12'h010, 2'b10, B};
    v[15] = '{2'b00, 12'h000, 12'h000, Z, Z, 2'b11, 12'h010, 12'h020, 2'b00, 2'b01, 1'b0, 12'h123, 64'h77, 1'b1, 12'h020, 2'b01, A};
    v[16] = '{2'b00, 12'h000, 12'h000, Z, Z, 2'b11, 12'h010, 12'h020, 2'b00, 2'b10, 1'b0, 12'h123, 64'h77, 1'b1, 12'h010, 2'b10, B};
    v[17] = '{2'b00, 12'h000, 12'h000, Z, Z, 2'b11, 12'h010, 12'h020, 2'b00, 2'b01, 1'b0, 12'h123, 64'h77, 1'b1, 12'h020, 2'b01, A};
    v[18] = '{2'b00, 12'h000, 12'h000, Z, Z, 2'b00, 12'h000, 12'h000, 2'b00, 2'b00, 1'b0, 12'h123, 64'h77, 1'b1, 12'h010, 2'b10, B};
    v[19] = '{2'b00, 12'h000, 12'h000, Z, Z, 2'b00, 12'h000, 12'h000, 2'b00, 2'b00, 1'b0, 12'h123, 64'h77, 1'b0, 12'h010, 2'b01, A};
    v[20] = '{2'b10, 12'h000, 12'h000, Z, 64'h1234, 2'b10, 12'h000, 12'hFFF, 2'b10, 2'b10, 1'b0, 12'h123, 64'h77, 1'b0, 12'h010, 2'b00, Z};
    v[21] = '{2'b00, 12'h000, 12'h000, Z, Z, 2'b00, 12'h000, 12'h000, 2'b00, 2'b00, 1'b1, 12'h000, 64'h1234, 1'b1, 12'hFFF, 2'b00, Z};
    v[22] = '{2'b00, 12'h000, 12'h000, Z, Z, 2'b00, 12'h000, 12'h000, 2'b00, 2'b00, 1'b0, 12'h000, 64'h1234, 1'b0, 12'hFFF, 2'b10, D};

    @(negedge clk);
    chk("reset wr", DW'(wr), Z);
    chk("reset rd", DW'(rd), Z);
    chk("reset rvalid", DW'(rvalid), Z);
    chk("reset wr_add", DW'(wr_add), Z);
    chk("reset rd_add", DW'(rd_add), Z);
    chk("reset in", in, Z);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    for (int c = 0; c < 23; c++) begin
      drive(v[c].wreq, v[c].wa0, v[c].wa1, v[c].wd0, v[c].wd1, v[c].rreq, v[c].ra0, v[c].ra1);
      @(negedge clk);
      chk($sformatf("c%0d wgnt", c), DW'(wgnt), DW'(v[c].wgnt));
      chk($sformatf("c%0d rgnt", c), DW'(rgnt), DW'(v[c].rgnt));
      chk($sformatf("c%0d wr", c), DW'(wr), DW'(v[c].wr));
      chk($sformatf("c%0d wr_add", c), DW'(wr_add), DW'(v[c].wa));
      chk($sformatf("c%0d in", c), in, v[c].din);
      chk($sformatf("c%0d rd", c), DW'(rd), DW'(v[c].rd));
      chk($sformatf("c%0d rd_add", c), DW'(rd_add), DW'(v[c].ra));
      chk($sformatf("c%0d rvalid", c), DW'(rvalid), DW'(v[c].rv));
      if (v[c].rv != 2'b00) chk($sformatf("c%0d rdata", c), rdata, v[c].rdat);
      @(posedge clk);
      #1;
    end

    drive(2'b01, 12'h050, 12'h000, 64'h99, Z, 2'b01, 12'h010, 12'h000);
    @(negedge clk);
    chk("pre-reset wgnt", DW'(wgnt), DW'(2'b01));
    chk("pre-reset rgnt", DW'(rgnt), DW'(2'b01));
    @(posedge clk);
    #1;
    drive(2'b00, 12'h000, 12'h000, Z, Z, 2'b00, 12'h000, 12'h000);
    rst_n = 1'b0;
    @(negedge clk);
    chk("mid-reset wr", DW'(wr), Z);
    chk("mid-reset rd", DW'(rd), Z);
    chk("mid-reset rvalid", DW'(rvalid), Z);
    chk("mid-reset wr_add", DW'(wr_add), Z);
    chk("mid-reset rd_add", DW'(rd_add), Z);
    @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      chk($sformatf("post-reset rvalid %0d", c), DW'(rvalid), Z);
    end
    @(posedge clk);
    #1;
    drive(2'b11, 12'h060, 12'h070, 64'h1, 64'h2, 2'b11, 12'h010, 12'h020);
    @(negedge clk);
    chk("post-reset wgnt", DW'(wgnt), DW'(2'b01));
    chk("post-reset rgnt", DW'(rgnt), DW'(2'b01));
    @(posedge clk);
    #1;
    drive(2'b00, 12'h000, 12'h000, Z, Z, 2'b00, 12'h000, 12'h000);
    @(negedge clk);
    chk("post-reset wr", DW'(wr), DW'(1'b1));
    chk("post-reset rd_add", DW'(rd_add), DW'(12'h010));
    @(negedge clk);
    chk("post-reset read rvalid", DW'(rvalid), DW'(2'b01));
    chk("post-reset read rdata", rdata, A);
    repeat (2) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
